// File: rtl/rom_pair_pkg.sv
// Shared widths and state encoding for the ROM pair fetch sequencer.
package rom_pair_pkg;

    localparam int ADDR_W = 8;
    localparam int DATA_W = 4;
    localparam int CNT_W  = 7;

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        READ_A  = 3'd1,
        READ_B  = 3'd2,
        LOAD_B  = 3'd3,
        PRESENT = 3'd4,
        DONE    = 3'd5
    } pair_state_t;

endpackage

// File: rtl/rom_pair_fetch.sv
// Reads word pairs from a one-cycle-latency ROM and presents them to the adder
// stage under a valid/ready handshake. Operands pass through untouched.
module rom_pair_fetch #(
    parameter int ADDR_W = rom_pair_pkg::ADDR_W,
    parameter int DATA_W = rom_pair_pkg::DATA_W,
    parameter int CNT_W  = rom_pair_pkg::CNT_W
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    input  logic [ADDR_W-1:0] base_addr,
    input  logic [CNT_W-1:0]  pair_count,
    output logic [ADDR_W-1:0] rom_addr,
    input  logic [DATA_W-1:0] rom_data,
    output logic [DATA_W-1:0] a_out,
    output logic [DATA_W-1:0] b_out,
    output logic              pair_valid,
    input  logic              pair_ready,
    output logic              busy,
    output logic              done
);
    import rom_pair_pkg::*;

    pair_state_t       r_state;
    pair_state_t       w_next_state;
    logic [ADDR_W-1:0] r_ptr;
    logic [CNT_W-1:0]  r_remaining;
    logic [DATA_W-1:0] r_a;
    logic [DATA_W-1:0] r_b;
    logic [ADDR_W-1:0] w_rom_addr;

    // State, pointer, counter and operand registers
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state     <= IDLE;
            r_ptr       <= '0;
            r_remaining <= '0;
            r_a         <= '0;
            r_b         <= '0;
        end else begin
            r_state <= w_next_state;
            case (r_state)
                IDLE: begin
                    if (start) begin
                        r_ptr       <= base_addr;
                        r_remaining <= pair_count;
                    end
                end
                // ROM data lags the address by one cycle, so A lands in READ_B
                READ_B:  r_a <= rom_data;
                LOAD_B:  r_b <= rom_data;
                PRESENT: begin
                    if (pair_ready) begin
                        r_ptr       <= r_ptr + ADDR_W'(2);
                        r_remaining <= r_remaining - CNT_W'(1);
                    end
                end
                default: ;
            endcase
        end
    end

    // Next-state selection and ROM address generation
    always_comb begin
        w_next_state = r_state;
        w_rom_addr   = r_ptr;
        case (r_state)
            IDLE: begin
                if (!start) begin
                    w_next_state = IDLE;
                end else if (pair_count == CNT_W'(0)) begin
                    w_next_state = DONE;
                end else begin
                    w_next_state = READ_A;
                end
            end
            READ_A: w_next_state = READ_B;
            READ_B: begin
                w_rom_addr   = r_ptr + ADDR_W'(1);
                w_next_state = LOAD_B;
            end
            LOAD_B: w_next_state = PRESENT;
            PRESENT: begin
                if (!pair_ready) begin
                    w_next_state = PRESENT;
                end else if (r_remaining == CNT_W'(1)) begin
                    w_next_state = DONE;
                end else begin
                    w_next_state = READ_A;
                end
            end
            DONE:    w_next_state = IDLE;
            default: w_next_state = IDLE;
        endcase
    end

    assign rom_addr   = w_rom_addr;
    assign a_out      = r_a;
    assign b_out      = r_b;
    assign pair_valid = (r_state == PRESENT);
    assign busy       = (r_state != IDLE);
    assign done       = (r_state == DONE);

endmodule

// File: tb/tb_rom_pair_fetch.sv
// Self-checking bench: table of runs applied in a loop with a pair scoreboard,
// plus hand-written reset and mid-run-reset sequences.
module tb_rom_pair_fetch;

    logic       clk = 1'b0;
    logic       reset;
    logic       start;
    logic [7:0] base_addr;
    logic [6:0] pair_count;
    logic [7:0] rom_addr;
    logic [3:0] rom_data;
    logic [3:0] a_out;
    logic [3:0] b_out;
    logic       pair_valid;
    logic       pair_ready;
    logic       busy;
    logic       done;

    int n_checks = 0;
    int n_fail   = 0;

    typedef struct packed {
        logic [3:0] a;
        logic [3:0] b;
    } pair_t;

    typedef struct {
        logic [7:0] base;
        logic [6:0] cnt;
        int         stall_from;
        int         stall_to;
        int         restart_at;
        bit         chk_addr;
        int         exp_v0;
        int         exp_v1;
        int         exp_done;
    } job_t;

    pair_t sb_q[$];
    job_t  jobs[7];

    rom_pair_fetch dut (
        .clk        (clk),
        .reset      (reset),
        .start      (start),
        .base_addr  (base_addr),
        .pair_count (pair_count),
        .rom_addr   (rom_addr),
        .rom_data   (rom_data),
        .a_out      (a_out),
        .b_out      (b_out),
        .pair_valid (pair_valid),
        .pair_ready (pair_ready),
        .busy       (busy),
        .done       (done)
    );

    always #5 clk = ~clk;

    // Behavioural ROM: mem[i] = i[3:0], one cycle read latency
    always_ff @(posedge clk) rom_data <= rom_addr[3:0];

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string name, input int act, input int exp);
        n_checks++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic run_job(input job_t j);
        int         vstart[2];
        int         v_idx;
        logic       prev_v;
        bit         got_done;
        logic [7:0] aa;
        logic [7:0] bb;
        pair_t      p;
        vstart   = '{-1, -1};
        v_idx    = 0;
        prev_v   = 1'b0;
        got_done = 1'b0;
        for (int k = 0; k < int'(j.cnt); k++) begin
            aa = j.base + 8'(2 * k);
            bb = aa + 8'd1;
            p.a = aa[3:0];
            p.b = bb[3:0];
            sb_q.push_back(p);
        end
        for (int c = 0; c < 400; c++) begin
            start      = (c == 0) || (c == j.restart_at);
            base_addr  = (c == 0) ? j.base : j.base + 8'h40;
            pair_count = j.cnt;
            pair_ready = !(c >= j.stall_from && c <= j.stall_to);
            if (j.chk_addr && c == 1) chk("addr_c1", int'(rom_addr), int'(j.base));
            if (j.chk_addr && c == 2) chk("addr_c2", int'(rom_addr), int'(8'(j.base + 8'd1)));
            if (j.chk_addr && c == 5) chk("addr_c5", int'(rom_addr), int'(8'(j.base + 8'd2)));
            if (j.chk_addr && c == 6) chk("addr_c6", int'(rom_addr), int'(8'(j.base + 8'd3)));
            if (pair_valid && !prev_v && v_idx < 2) begin
                vstart[v_idx] = c;
                v_idx++;
            end
            if (pair_valid) begin
                if (sb_q.size() == 0) begin
                    chk("extra_pair", 1, 0);
                end else if (pair_ready) begin
                    p = sb_q.pop_front();
                    chk("pair_a", int'(a_out), int'(p.a));
                    chk("pair_b", int'(b_out), int'(p.b));
                end else begin
                    chk("hold_a", int'(a_out), int'(sb_q[0].a));
                    chk("hold_b", int'(b_out), int'(sb_q[0].b));
                end
            end
            prev_v = pair_valid;
            if (done) begin
                chk("done_cycle", c, j.exp_done);
                got_done = 1'b1;
            end
            tick();
            if (got_done) break;
        end
        start      = 1'b0;
        pair_ready = 1'b1;
        if (!got_done) chk("done_timeout", 0, 1);
        chk("valid0_cycle", vstart[0], j.exp_v0);
        chk("valid1_cycle", vstart[1], j.exp_v1);
        chk("sb_leftover", sb_q.size(), 0);
        chk("busy_after", int'(busy), 0);
        chk("done_after", int'(done), 0);
        sb_q.delete();
    endtask

    initial begin
        int stray;
        //          base   cnt  stl_f stl_t rst  addr v0  v1  done
        jobs[0] = '{8'h10, 7'd2, -1, -1, -1, 1'b1, 4,  8,  9};
        jobs[1] = '{8'h10, 7'd2,  4,  6, -1, 1'b0, 4, 11, 12};
        jobs[2] = '{8'hFE, 7'd2, -1, -1, -1, 1'b1, 4,  8,  9};
        jobs[3] = '{8'h00, 7'd0, -1, -1, -1, 1'b0, -1, -1, 1};
        jobs[4] = '{8'h10, 7'd2, -1, -1,  2, 1'b0, 4,  8,  9};
        jobs[5] = '{8'h35, 7'd5, -1, -1, -1, 1'b0, 4,  8, 21};
        jobs[6] = '{8'h00, 7'd1, -1, -1, -1, 1'b0, 4, -1,  5};

        reset      = 1'b1;
        start      = 1'b0;
        base_addr  = 8'h00;
        pair_count = 7'd0;
        pair_ready = 1'b1;
        tick();
        tick();
        reset = 1'b0;
        chk("rst_rom_addr", int'(rom_addr), 0);
        chk("rst_a_out", int'(a_out), 0);
        chk("rst_b_out", int'(b_out), 0);
        chk("rst_valid", int'(pair_valid), 0);
        chk("rst_busy", int'(busy), 0);
        chk("rst_done", int'(done), 0);
        tick();

        for (int i = 0; i < 6; i++) begin
            run_job(jobs[i]);
            tick();
        end

        // Mid-run reset while in LOAD_B (cycle 3)
        base_addr  = 8'h27;
        pair_count = 7'd2;
        start      = 1'b1;
        tick();
        start = 1'b0;
        tick();
        tick();
        chk("mid_busy_pre", int'(busy), 1);
        reset = 1'b1;
        tick();
        reset = 1'b0;
        chk("mid_valid", int'(pair_valid), 0);
        chk("mid_busy", int'(busy), 0);
        chk("mid_done", int'(done), 0);
        chk("mid_a_out", int'(a_out), 0);
        chk("mid_b_out", int'(b_out), 0);
        chk("mid_rom_addr", int'(rom_addr), 0);
        stray = 0;
        for (int c = 0; c < 10; c++) begin
            if (done || pair_valid || busy) stray++;
            tick();
        end
        chk("mid_stray", stray, 0);
        run_job(jobs[6]);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/rom_pair_fetch.md
# rom_pair_fetch

Sequencer between the `sync_rom` operand store and the `sign_mag_add` combinational adder. On `start` it reads `pair_count` consecutive word pairs from the ROM, beginning at `base_addr`. It absorbs the ROM's one-cycle read latency and presents each pair as `a_out`/`b_out` under a valid/ready handshake to the adder stage. Operand values are 4-bit sign-magnitude and pass through unmodified.

## Interface
Parameters:
- `ADDR_W`, 8, ROM address width
- `DATA_W`, 4, ROM word / operand width (sign-magnitude: MSB sign, low 3 bits magnitude)
- `CNT_W`, 7, width of `pair_count`

Ports:
- `clk`  in  1  single clock; all state updates on rising edge
- `reset`  in  1  synchronous, active-high
- `start`  in  1  request a run; sampled only in IDLE
- `base_addr`  in  ADDR_W  first ROM address of the run
- `pair_count`  in  CNT_W  number of pairs to fetch (0..127)
- `rom_addr`  out  ADDR_W  address to `sync_rom`
- `rom_data`  in  DATA_W  `sync_rom` output; shows mem[addr] one cycle after addr is driven
- `a_out`, `b_out`  out  DATA_W  operand pair to adder
- `pair_valid`  out  1  pair on `a_out`/`b_out` is valid
- `pair_ready`  in  1  downstream accepts pair
- `busy`  out  1  high whenever state != IDLE
- `done`  out  1  one-cycle pulse when a run completes

## Operation
- States: IDLE, READ_A, READ_B, LOAD_B, PRESENT, DONE.
- IDLE: on `start` latch `ptr <= base_addr`, `remaining <= pair_count`.
  - If `pair_count == 0`: go to DONE.
  - Otherwise: go to READ_A.
- READ_A: `rom_addr = ptr`; go to READ_B.
- READ_B: `rom_addr = ptr + 1`; `a_reg <= rom_data`; go to LOAD_B.
- LOAD_B: `b_reg <= rom_data`; go to PRESENT.
- PRESENT: `pair_valid = 1`; `a_out`/`b_out` are held stable.
  - On `pair_valid && pair_ready`: `ptr <= ptr + 2`, `remaining <= remaining - 1`.
  - Then go to DONE if `remaining == 1`, else to READ_A.
- DONE: `done = 1` for exactly one cycle; go to IDLE.
- Address arithmetic is modulo 2^ADDR_W; `ptr + 1` and `ptr + 2` wrap (0xFF -> 0x00).
- `start` is ignored outside IDLE.
- No sign-magnitude interpretation. Negative zero (4'b1000) is passed verbatim.
- `rom_addr` equals `ptr` in every state other than READ_B; `rom_data` is ignored outside READ_B/LOAD_B.

## Timing
- Reset values:
  - state = IDLE
  - `ptr`, `remaining`, `a_reg`, `b_reg` = 0
  - `rom_addr` = 0, `a_out` = 0, `b_out` = 0
  - `pair_valid`, `busy`, `done` = 0
- Count cycles from the cycle in which `start` is sampled high (cycle 0).
- First pair: READ_A in cycle 1, READ_B in cycle 2, LOAD_B in cycle 3, `pair_valid` from cycle 4.
- Throughput: 4 cycles per pair when `pair_ready` is held high.
- `done` is asserted in the cycle after the final handshake.
- `pair_count == 0`: `done` in cycle 1, with no `pair_valid` and no ROM read.
- Backpressure: in PRESENT, `pair_valid` stays high and `a_out`/`b_out` stay constant until `pair_ready`. There is no timeout.
- `reset` asserted in any state returns to IDLE at the next edge. The run is aborted with no `done` pulse, and all outputs take reset values.

## Structure
- Package `rom_pair_pkg`:
  - state enum `pair_state_t` (IDLE..DONE)
  - localparams `ADDR_W`, `DATA_W`, `CNT_W`
- Single flat module with no sub-modules. One `always_ff` block for state and datapath registers, one `always_comb` block for next-state logic and `rom_addr`.
- Top level instantiates `sync_rom`, `rom_pair_fetch` and `sign_mag_add` side by side.

## Test plan
The bench uses a behavioural ROM with mem[i] = i[3:0].
- Reset: hold `reset` for 2 cycles, then release -> all outputs 0, `busy` = 0, `rom_addr` = 0.
- Basic run: `base_addr` = 0x10, `pair_count` = 2, `pair_ready` = 1.
  - `rom_addr` sequence 10,11,12,13.
  - Pair (0000,0001) valid in cycle 4; pair (0010,0011) valid in cycle 8.
  - `done` in cycle 9; `busy` low in cycle 10.
- Backpressure: as the basic run, with `pair_ready` = 0 for cycles 4–6 -> `pair_valid` held and `a_out`/`b_out` = 0000/0001 stable; handshake in cycle 7; second pair valid in cycle 11.
- Wrap: `base_addr` = 0xFE, `pair_count` = 2 -> addresses FE,FF,00,01; pairs (1110,1111) and (0000,0001), where 1111 is negative 7.
- Zero count, and start while busy:
  - `pair_count` = 0 -> `done` in cycle 1 and `pair_valid` never asserts.
  - A second `start` pulsed in cycle 2 of a running job is ignored and yields no extra pairs.
- Mid-run reset: assert `reset` during LOAD_B -> IDLE the next cycle, `pair_valid` = 0, no `done`. A new run from `base_addr` = 0 then yields (0000,0001) in cycle 4.
